// File: rtl/immediate_unit.sv
// Immediate merge unit: builds MOVL/MOVLZ/MOVLS/MOVH results, optionally with prefix bytes.
// Latency: 1 cycle from accepted non-prefix word to valid_o; prefix words produce no output.
// Backpressure: ready_o = !valid_o || ready_i; a stalled result holds and blocks new input.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i / ready_o   input handshake (instWord_i, rdVal_i, prefix_i)
//   valid_o / ready_i   output handshake (immVal_o)
//   err_o               one-cycle pulse when a prefix arrives with the accumulator full
//
// Build option: define IMM_PREFIX_EN to compile in prefix accumulation. Without it
// prefix_i is ignored, every word is a plain immediate and err_o is tied low.
module immediate_unit #(
  parameter  int WORD = 16,
  localparam int INST = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [INST-1:0] instWord_i,
  input  logic [WORD-1:0] rdVal_i,
  input  logic            prefix_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [WORD-1:0] immVal_o,
  output logic            err_o
);

  localparam int NB = WORD / 8;
  localparam int KW = $clog2(NB);

  localparam logic [1:0] OP_MOVL  = 2'd0;
  localparam logic [1:0] OP_MOVLZ = 2'd1;
  localparam logic [1:0] OP_MOVLS = 2'd2;
  localparam logic [1:0] OP_MOVH  = 2'd3;

  logic [1:0]      op;
  logic [7:0]      imm8;
  logic            xfer;
  logic            is_pfx;
  logic [WORD-9:0] acc_q;
  logic [KW-1:0]   k_q;
  logic [WORD-1:0] res;
  logic            valid_q;
  logic [WORD-1:0] imm_q;
  logic            unused_ok;

  assign op   = instWord_i[12:11];
  assign imm8 = instWord_i[10:3];

  assign ready_o = !valid_q || ready_i;
  assign xfer    = valid_i && ready_o;

  // Only the type and imm8 fields carry meaning.
  assign unused_ok = &{1'b0, instWord_i[15:13], instWord_i[2:0], prefix_i};

`ifdef IMM_PREFIX_EN
  localparam logic [KW-1:0] KMAX = KW'(NB - 1);

  typedef enum logic {EMPTY, ACCUM} pstate_t;

  pstate_t         state_q, state_d;
  logic [WORD-9:0] acc_d;
  logic [KW-1:0]   k_d;
  logic            err_d, err_q;
  logic [WORD-1:0] shifted;

  assign is_pfx  = prefix_i;
  // Newest byte enters at the bottom; the oldest falls off the top when full.
  assign shifted = {acc_q, imm8};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    err_d   = 1'b0;
    if (xfer && !is_pfx) begin
      state_d = EMPTY;
      acc_d   = '0;
      k_d     = '0;
    end else if (xfer) begin
      acc_d = shifted[WORD-9:0];
      case (state_q)
        EMPTY: begin
          state_d = ACCUM;
          k_d     = KW'(1);
        end
        ACCUM: begin
          if (k_q == KMAX) begin
            err_d = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign is_pfx = 1'b0;
  assign acc_q  = '0;
  assign k_q    = '0;
  assign err_o  = 1'b0;
`endif

  function automatic logic [7:0] acc_byte(input logic [WORD-9:0] a, input int i);
    logic [WORD-9:0] t;
    t = a >> (8 * i);
    return t[7:0];
  endfunction

  // Byte-wise merge. Non-MOVH: byte 0 = imm8, bytes 1..k = prefix bytes, rest = fill.
  // MOVH shifts that layout up one byte over rdVal_i[7:0]; with k saturated the
  // oldest prefix byte lands beyond WORD and is simply not emitted.
  always_comb begin
    res = '0;
    for (int b = 0; b < NB; b++) begin
      if (op == OP_MOVH) begin
        if (b == 0) begin
          res[8*b +: 8] = rdVal_i[7:0];
        end else if (b == 1) begin
          res[8*b +: 8] = imm8;
        end else if (b <= int'(k_q) + 1) begin
          res[8*b +: 8] = acc_byte(acc_q, (b >= 2) ? b - 2 : 0);
        end else begin
          res[8*b +: 8] = rdVal_i[8*b +: 8];
        end
      end else begin
        if (b == 0) begin
          res[8*b +: 8] = imm8;
        end else if (b <= int'(k_q)) begin
          res[8*b +: 8] = acc_byte(acc_q, (b >= 1) ? b - 1 : 0);
        end else if (op == OP_MOVLZ) begin
          res[8*b +: 8] = 8'h00;
        end else if (op == OP_MOVLS) begin
          res[8*b +: 8] = 8'hFF;
        end else if (op == OP_MOVL) begin
          res[8*b +: 8] = rdVal_i[8*b +: 8];
        end else begin
          res[8*b +: 8] = 8'h00;
        end
      end
    end
  end

  // A new result may replace one draining in the same cycle, keeping valid_o high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
    end else if (xfer && !is_pfx) begin
      valid_q <= 1'b1;
      imm_q   <= res;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign immVal_o = imm_q;

endmodule

// File: tb/tb_immediate_unit.sv
// Bench for immediate_unit: 16- and 32-bit instances share one stimulus stream.
// Directed vectors first, then randomized traffic with random stalls and resets.
// A queue-based reference model predicts every output cycle by cycle.
module tb_immediate_unit;

`ifdef IMM_PREFIX_EN
  localparam bit PFX_EN = 1'b1;
`else
  localparam bit PFX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        pfx = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] inst = '0;
  logic [31:0] rd = '0;

  logic        rdy16, vld16, err16;
  logic [15:0] val16;
  logic        rdy32, vld32, err32;
  logic [31:0] val32;

  always #5 clk = ~clk;

  immediate_unit #(.WORD(16)) u16 (
    .clk_i(clk), .rst_i(rst), .valid_i(vld), .ready_o(rdy16),
    .instWord_i(inst), .rdVal_i(rd[15:0]), .prefix_i(pfx),
    .valid_o(vld16), .ready_i(rdy), .immVal_o(val16), .err_o(err16)
  );

  immediate_unit #(.WORD(32)) u32 (
    .clk_i(clk), .rst_i(rst), .valid_i(vld), .ready_o(rdy32),
    .instWord_i(inst), .rdVal_i(rd), .prefix_i(pfx),
    .valid_o(vld32), .ready_i(rdy), .immVal_o(val32), .err_o(err32)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: result register plus the retained prefix bytes (oldest first).
  logic        m_vld = 1'b0;
  logic [63:0] m_v16 = '0;
  logic [63:0] m_v32 = '0;
  logic        m_e16 = 1'b0;
  logic        m_e32 = 1'b0;
  logic [7:0]  q16[$];
  logic [7:0]  q32[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] low_mask(input int bits);
    if (bits >= 64) return '1;
    return (64'd1 << bits) - 64'd1;
  endfunction

  function automatic logic [63:0] qval(input logic [7:0] q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) v = (v << 8) | 64'(q[i]);
    return v;
  endfunction

  // Arithmetic form of the merge: imm8 preceded by the prefix value, with the
  // region above it filled from zeros, ones or the old register.
  function automatic logic [63:0] ref_calc(input int w, input logic [15:0] iw,
                                           input logic [63:0] rdv, input logic [7:0] q[$]);
    logic [63:0] pre, lo, m1, m2, r;
    int k;
    k   = q.size();
    pre = qval(q);
    lo  = (pre << 8) | 64'(iw[10:3]);
    m1  = low_mask(8 * (k + 1));
    m2  = low_mask(8 * (k + 2));
    case (iw[12:11])
      2'd0:    r = (rdv & ~m1) | lo;
      2'd1:    r = lo;
      2'd2:    r = ~m1 | lo;
      default: r = (rdv & ~m2) | (lo << 8) | 64'(rdv[7:0]);
    endcase
    return r & low_mask(w);
  endfunction

  task automatic step(input bit r, input bit v, input logic [15:0] iw, input bit p,
                      input logic [31:0] d, input bit rdi);
    bit rdyo, x, pp;
    if (r) begin
      m_vld = 1'b0; m_v16 = '0; m_v32 = '0; m_e16 = 1'b0; m_e32 = 1'b0;
      q16.delete(); q32.delete();
      return;
    end
    rdyo = !m_vld || rdi;
    x    = v && rdyo;
    pp   = PFX_EN && p;
    m_e16 = 1'b0;
    m_e32 = 1'b0;
    if (x && pp) begin
      q16.push_back(iw[10:3]);
      if (q16.size() > 1) begin void'(q16.pop_front()); m_e16 = 1'b1; end
      q32.push_back(iw[10:3]);
      if (q32.size() > 3) begin void'(q32.pop_front()); m_e32 = 1'b1; end
    end
    if (x && !pp) begin
      m_v16 = ref_calc(16, iw, 64'(d[15:0]), q16);
      m_v32 = ref_calc(32, iw, 64'(d), q32);
      q16.delete();
      q32.delete();
      m_vld = 1'b1;
    end else if (rdi) begin
      m_vld = 1'b0;
    end
  endtask

  // One clock: check state left by the previous edge, drive new inputs, predict.
  task automatic cyc(input bit r, input bit v, input logic [15:0] iw, input bit p,
                     input logic [31:0] d, input bit rdi);
    @(negedge clk);
    chk("valid16", 64'(vld16), 64'(m_vld));
    chk("valid32", 64'(vld32), 64'(m_vld));
    chk("imm16", 64'(val16), m_v16);
    chk("imm32", 64'(val32), m_v32);
    chk("err16", 64'(err16), 64'(m_e16));
    chk("err32", 64'(err32), 64'(m_e32));
    rst = r; vld = v; inst = iw; pfx = p; rd = d; rdy = rdi;
    #1;
    chk("ready16", 64'(rdy16), 64'(!m_vld || rdi));
    chk("ready32", 64'(rdy32), 64'(!m_vld || rdi));
    step(r, v, iw, p, d, rdi);
  endtask

  task automatic idle(input bit rdi);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 32'h0000BEEF, rdi);
  endtask

  task automatic put(input logic [15:0] iw, input bit p, input bit rdi);
    cyc(1'b0, 1'b1, iw, p, 32'h0000BEEF, rdi);
  endtask

  initial begin
    // Reset state and ready right after reset release.
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    chk("rst_valid16", 64'(vld16), 64'h0);
    chk("rst_imm16", 64'(val16), 64'h0);
    chk("rst_imm32", 64'(val32), 64'h0);
    idle(1'b0);
    chk("rst_ready16", 64'(rdy16), 64'h1);

    // Basic merges.
    put(16'h0D28, 1'b0, 1'b1); idle(1'b1);
    chk("movlz_a5", 64'(val16), 64'h00A5);
    chk("movlz_a5_vld", 64'(vld16), 64'h1);
    put(16'h1400, 1'b0, 1'b1); idle(1'b1);
    chk("movls_80", 64'(val16), 64'hFF80);
    chk("movls_80_w32", 64'(val32), 64'hFFFFFF80);
    put(16'h01A0, 1'b0, 1'b1); idle(1'b1);
    chk("movl_be34", 64'(val16), 64'hBE34);
    put(16'h1890, 1'b0, 1'b1); idle(1'b1);
    chk("movh_12ef", 64'(val16), 64'h12EF);

    // Prefix accumulation, saturation on the 16-bit instance.
    put(16'h0090, 1'b1, 1'b1);
    put(16'h01A0, 1'b1, 1'b1);
    put(16'h0AB0, 1'b0, 1'b1);
`ifdef IMM_PREFIX_EN
    chk("pfx_err16", 64'(err16), 64'h1);
    chk("pfx_err32", 64'(err32), 64'h0);
`else
    chk("nopfx_err16", 64'(err16), 64'h0);
`endif
    idle(1'b1);
`ifdef IMM_PREFIX_EN
    chk("pfx_movlz32", 64'(val32), 64'h00123456);
    chk("pfx_movlz16", 64'(val16), 64'h3456);
`endif
    put(16'h0090, 1'b1, 1'b1);
    put(16'h01A0, 1'b1, 1'b1);
    put(16'h12B0, 1'b0, 1'b1);
    idle(1'b1);
`ifdef IMM_PREFIX_EN
    chk("pfx_movls32", 64'(val32), 64'hFF123456);
`endif
    put(16'h0D28, 1'b0, 1'b1); idle(1'b1);
    chk("k_cleared32", 64'(val32), 64'h000000A5);

    // Backpressure: hold, then back-to-back replacement.
    put(16'h0D28, 1'b0, 1'b0);
    put(16'h1400, 1'b0, 1'b0);
    chk("bp_ready", 64'(rdy16), 64'h0);
    chk("bp_hold", 64'(val16), 64'h00A5);
    put(16'h1400, 1'b0, 1'b0);
    put(16'h1400, 1'b0, 1'b1);
    idle(1'b0);
    chk("bp_b2b_vld", 64'(vld16), 64'h1);
    chk("bp_b2b_val", 64'(val16), 64'hFF80);
    idle(1'b1);

    // Reset with a partial prefix, then with a pending result.
    put(16'h0090, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b1);
    idle(1'b1);
    chk("rst_pfx_vld", 64'(vld16), 64'h0);
    chk("rst_pfx_imm", 64'(val16), 64'h0);
    put(16'h0D28, 1'b0, 1'b1); idle(1'b1);
    chk("post_rst16", 64'(val16), 64'h00A5);
    chk("post_rst32", 64'(val32), 64'h000000A5);
    put(16'h1400, 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    chk("rst_pend_vld", 64'(vld16), 64'h0);
    chk("rst_pend_imm", 64'(val32), 64'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 16'($urandom),
          $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 9) < 6);
    end
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/immediate_unit.md
IMMEDIATE_UNIT -- requirements
Module: immediate_unit

Interface
REQ-001 Parameter WORD, default 16, datapath width in bits; SHALL be a multiple of 8 in the range 16..64.
REQ-002 Parameter INST, default 16, instruction word width; fixed at 16, not overridable.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 valid_i  input  1  instruction word and register value are presented this cycle.
REQ-006 ready_o  output  1  unit accepts input this cycle.
REQ-007 instWord_i  input  INST  instruction; bits 12:11 = type (0 MOVL, 1 MOVLZ, 2 MOVLS, 3 MOVH); bits 10:3 = imm8.
REQ-008 rdVal_i  input  WORD  current destination register value, used for merge.
REQ-009 prefix_i  input  1  word is an immediate-prefix carrying imm8 only; type bits ignored.
REQ-010 valid_o  output  1  immVal_o holds a result.
REQ-011 ready_i  input  1  consumer takes the result this cycle.
REQ-012 immVal_o  output  WORD  merged immediate result.
REQ-013 err_o  output  1  one-cycle pulse on prefix overflow.

Function
REQ-014 Transfer occurs when valid_i && ready_o; ready_o = !valid_o || ready_i (combinational, independent of prefix_i).
REQ-015 Non-prefix transfer SHALL load immVal_o and set valid_o on the next edge; latency is 1 cycle.
REQ-016 Output drains when valid_o && ready_i; valid_o clears unless a new non-prefix transfer occurs in the same cycle, in which case the new result loads and valid_o stays 1.
REQ-017 While valid_o && !ready_i, immVal_o and valid_o SHALL hold stable and no input is accepted.
REQ-018 Prefix state = accumulator acc (WORD-8 bits) plus count k (0..WORD/8-1).
REQ-019 Prefix transfer: acc = {acc[WORD-17:0], imm8}, k = k+1; no output is produced.
REQ-020 Prefix transfer with k = WORD/8-1 (saturated) SHALL still shift acc, dropping the oldest byte; k stays saturated and err_o pulses high for 1 cycle.
REQ-021 MOVLZ result = {zeros, low k bytes of acc, imm8}.
REQ-022 MOVLS result = {ones, low k bytes of acc, imm8}.
REQ-023 MOVL result = {rdVal_i bits above 8(k+1), low k bytes of acc, imm8}.
REQ-024 MOVH with k <= WORD/8-2: result = {rdVal_i bits above 8(k+2), low k bytes of acc, imm8, rdVal_i[7:0]}.
REQ-025 MOVH with k = WORD/8-1: the top acc byte is discarded so the result fits WORD bits.
REQ-026 Any non-prefix transfer clears acc and k on the same edge it loads the result.
REQ-027 Prefix and drain in the same cycle are independent: the drain completes and acc updates.
REQ-028 Prefix-state machine: EMPTY (k=0) -> ACCUM on a prefix; ACCUM -> ACCUM on a prefix (saturating); any state -> EMPTY on a non-prefix transfer or reset.
REQ-029 Field extraction SHALL use instWord_i bits 12:11 and 10:3 regardless of WORD.

Reset
REQ-030 When rst_i is sampled high: valid_o=0, immVal_o=0, acc=0, k=0, err_o=0.
REQ-031 Reset mid-operation SHALL discard any pending result and partial prefix; the first input accepted after reset sees k=0.
REQ-032 ready_o=1 in the cycle after reset deasserts.

Configuration
REQ-033 Macro IMM_PREFIX_EN defined: prefix accumulation per REQ-018..REQ-028 is compiled in.
REQ-034 IMM_PREFIX_EN undefined: no acc or k storage; prefix_i ignored and every word is treated as non-prefix; k is effectively 0; err_o tied to 0.

Verification
REQ-035 WORD=16, MOVLZ instWord_i=0x0D28 -> one cycle later valid_o=1, immVal_o=0x00A5; MOVLS 0x1400 -> 0xFF80.
REQ-036 WORD=16, rdVal_i=0xBEEF: MOVL 0x01A0 -> 0xBE34; MOVH 0x1890 -> 0x12EF.
REQ-037 WORD=32 with IMM_PREFIX_EN: prefix 0x0090, prefix 0x01A0, then MOVLZ 0x0AB0 -> 0x00123456; repeat ending in MOVLS 0x12B0 -> 0xFF123456; k=0 afterwards.
REQ-038 WORD=16 with IMM_PREFIX_EN: prefix 0x0090, prefix 0x01A0 -> err_o pulses on the second; MOVLZ 0x0AB0 -> 0x3456.
REQ-039 Backpressure: hold ready_i=0 with a result pending, present a new valid_i -> ready_o=0 and immVal_o unchanged; raise ready_i with valid_i held -> result replaced back-to-back, valid_o continuous.
REQ-040 Assert rst_i after one prefix and with a result pending -> valid_o=0 and immVal_o=0; next MOVLZ 0x0D28 -> 0x00A5 (no stale prefix bytes).
